iterative_divider: RTL and testbench



---
 rtl/iterative_divider.sv | 163 ++++++++++++++++
 tb/tb_iterative_divider.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Radix-2 restoring integer divider with RISC-V special cases, optional
// leading-zero skip, W-mode sign extension and valid/ready result handshake.
//
// state | meaning
// IDLE  | waiting for a request, div_ready=1
// DIV   | one quotient bit per edge while cnt_r!=0; sign fix-up when cnt_r==0
// DONE  | result held on quotient/remainder until out_ready
module iterative_divider #(
    parameter int XLEN      = 64,
    parameter bit HAS_W     = 1,
    parameter bit EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic            divw,
    input  logic            div_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [63:0] LOW32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] MIN32 = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
    state_t state, state_nxt;

    logic [XLEN-1:0] dvd_r, dvs_r, rem_r, quo_r;
    logic [CW-1:0]   cnt_r;
    logic            qneg_r, rneg_r, w_r;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [63:0] t;
        t = {{32{v[31]}}, v[31:0]};
        return t[XLEN-1:0];
    endfunction

    function automatic logic [CW-1:0] clz(input logic [XLEN-1:0] v);
        logic [CW-1:0] n;
        n = CW'(XLEN);
        for (int i = 0; i < XLEN; i++)
            if (v[i]) n = CW'(XLEN - 1 - i);
        return n;
    endfunction

    logic            w_in, sign_a, sign_b, div0, ovf, special, accept;
    logic [XLEN-1:0] mask, min_n, a_n, b_n, a_sx, b_sx, a_abs, b_abs, a_al, a_pre;
    logic [XLEN-1:0] spec_q, spec_r;
    logic [CW-1:0]   n_in, lz, k_in;

    // Operand conditioning: N-bit magnitudes, left-aligned to XLEN so the
    // iteration always consumes dividend bits from the top of dvd_r.
    always_comb begin
        w_in   = divw & HAS_W;
        mask   = w_in ? LOW32[XLEN-1:0] : '1;
        min_n  = w_in ? MIN32[XLEN-1:0] : {1'b1, {(XLEN-1){1'b0}}};
        n_in   = w_in ? CW'(32) : CW'(XLEN);
        a_n    = dividend & mask;
        b_n    = divisor & mask;
        sign_a = div_signed & (w_in ? dividend[31] : dividend[XLEN-1]);
        sign_b = div_signed & (w_in ? divisor[31] : divisor[XLEN-1]);
        a_sx   = w_in ? sext32(dividend) : dividend;
        b_sx   = w_in ? sext32(divisor) : divisor;
        a_abs  = (sign_a ? -a_sx : a_sx) & mask;
        b_abs  = (sign_b ? -b_sx : b_sx) & mask;
        a_al   = a_abs << (XLEN - int'(n_in));
        lz     = clz(a_al);
        if (!EARLY_OUT)
            k_in = n_in;
        else if (a_al == '0)
            k_in = CW'(1);
        else
            k_in = n_in - lz;
        a_pre   = (EARLY_OUT && a_al != '0) ? (a_al << lz) : a_al;
        div0    = (b_n == '0);
        ovf     = div_signed & (a_n == min_n) & (b_n == mask);
        special = div0 | ovf;
        spec_q  = div0 ? mask : a_n;
        spec_r  = div0 ? a_n : '0;
        accept  = div_valid & div_ready & ~flush;
    end

    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] q_c, r_c;

    always_comb begin
        shifted = {rem_r, dvd_r[XLEN-1]};
        diff    = shifted - {1'b0, dvs_r};
        q_c     = qneg_r ? -quo_r : quo_r;
        r_c     = rneg_r ? -rem_r : rem_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_ready = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                div_ready = 1'b1;
                if (accept) state_nxt = special ? DONE : DIV;
            end
            DIV:  if (cnt_r == '0) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_r     <= '0;
            dvs_r     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            cnt_r     <= '0;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            w_r       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (state == IDLE && accept) begin
            if (special) begin
                quotient  <= w_in ? sext32(spec_q) : spec_q;
                remainder <= w_in ? sext32(spec_r) : spec_r;
            end else begin
                dvd_r  <= a_pre;
                dvs_r  <= b_abs;
                rem_r  <= '0;
                quo_r  <= '0;
                cnt_r  <= k_in;
                qneg_r <= sign_a ^ sign_b;
                rneg_r <= sign_a;
                w_r    <= w_in;
            end
        end else if (state == DIV && !flush) begin
            if (cnt_r != '0) begin
                rem_r <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], ~diff[XLEN]};
                dvd_r <= dvd_r << 1;
                cnt_r <= cnt_r - CW'(1);
            end else begin
                quotient  <= w_r ? sext32(q_c) : q_c;
                remainder <= w_r ? sext32(r_c) : r_c;
            end
        end
    end
endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench: two divider instances (fixed iteration count and
// early-out) share stimulus and are checked against an arithmetic model.
module tb_iterative_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        div_valid = 1'b0;
    logic        divw = 1'b0;
    logic        div_signed = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        out_ready = 1'b0;
    logic        ready0, ready1, ov0, ov1;
    logic [63:0] q0, r0, q1, r1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iterative_divider #(.XLEN(64), .HAS_W(1), .EARLY_OUT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .div_ready(ready0),
        .divw(divw), .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
        .out_valid(ov0), .out_ready(out_ready), .quotient(q0), .remainder(r0));

    iterative_divider #(.XLEN(64), .HAS_W(1), .EARLY_OUT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .div_valid(div_valid), .div_ready(ready1),
        .divw(divw), .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
        .out_valid(ov1), .out_ready(out_ready), .quotient(q1), .remainder(r1));

    // RISC-V division semantics; k0/k1 are iteration counts without/with early-out.
    function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                  input bit sgn, input bit w,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output int k0, output int k1, output bit spec);
        int n;
        int len;
        logic [63:0] mask, an, bn, mn, m;
        n    = w ? 32 : 64;
        mask = w ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        mn   = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        an   = a & mask;
        bn   = b & mask;
        spec = 1'b0;
        if (bn == 0) begin
            q = mask; r = an; spec = 1'b1;
        end else if (sgn && an == mn && bn == mask) begin
            q = an; r = 0; spec = 1'b1;
        end else if (sgn && w) begin
            int sa, sb, qi, ri;
            sa = a[31:0]; sb = b[31:0];
            qi = sa / sb; ri = sa % sb;
            q = {32'h0, qi}; r = {32'h0, ri};
        end else if (sgn) begin
            longint sa, sb;
            sa = a; sb = b;
            q = sa / sb; r = sa % sb;
        end else begin
            q = an / bn; r = an % bn;
        end
        if (w) begin
            q = {{32{q[31]}}, q[31:0]};
            r = {{32{r[31]}}, r[31:0]};
        end
        m = an;
        if (sgn && an[n-1]) m = (~an + 64'd1) & mask;
        len = 0;
        while (m != 0) begin len++; m = m >> 1; end
        k0 = n;
        k1 = (len == 0) ? 1 : len;
    endfunction

    // Starts and ends at #1 after a rising edge. Special results appear right
    // after the accept edge (latency 0); normal results K+1 edges after it.
    task automatic run_op(input string name, input logic [63:0] a, input logic [63:0] b,
                          input bit sgn, input bit w, input int hold);
        logic [63:0] eq, er, sq0, sr0, sq1, sr1;
        int k0, k1, lat0, lat1, e, exp0, exp1;
        bit spec, busy_bad0, busy_bad1, hold_bad;
        model(a, b, sgn, w, eq, er, k0, k1, spec);
        exp0 = spec ? 0 : k0 + 1;
        exp1 = spec ? 0 : k1 + 1;
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: got %b/%b expected 1/1", name, ready0, ready1);
        end
        div_valid = 1'b1; dividend = a; divisor = b; div_signed = sgn; divw = w;
        @(posedge clk); #1;
        div_valid = 1'b0;
        dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
        div_signed = 1'($urandom); divw = 1'($urandom);
        lat0 = -1; lat1 = -1; e = 0; busy_bad0 = 0; busy_bad1 = 0;
        while ((lat0 < 0 || lat1 < 0) && e < 200) begin
            if (ov0 && lat0 < 0) lat0 = e;
            if (ov1 && lat1 < 0) lat1 = e;
            if (lat0 < 0 && !ov0 && ready0) busy_bad0 = 1;
            if (lat1 < 0 && !ov1 && ready1) busy_bad1 = 1;
            if (lat0 < 0 || lat1 < 0) begin
                @(posedge clk); #1; e++;
            end
        end
        checks += 8;
        if (lat0 !== exp0) begin failures++; $display("FAIL %s lat0: got %0d expected %0d", name, lat0, exp0); end
        if (lat1 !== exp1) begin failures++; $display("FAIL %s lat1: got %0d expected %0d", name, lat1, exp1); end
        if (busy_bad0 !== 1'b0) begin failures++; $display("FAIL %s busy_ready0: got 1 expected 0", name); end
        if (busy_bad1 !== 1'b0) begin failures++; $display("FAIL %s busy_ready1: got 1 expected 0", name); end
        if (q0 !== eq) begin failures++; $display("FAIL %s q0: got %h expected %h", name, q0, eq); end
        if (r0 !== er) begin failures++; $display("FAIL %s r0: got %h expected %h", name, r0, er); end
        if (q1 !== eq) begin failures++; $display("FAIL %s q1: got %h expected %h", name, q1, eq); end
        if (r1 !== er) begin failures++; $display("FAIL %s r1: got %h expected %h", name, r1, er); end
        sq0 = q0; sr0 = r0; sq1 = q1; sr1 = r1; hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!ov0 || !ov1 || ready0 || ready1 || q0 !== sq0 || r0 !== sr0 || q1 !== sq1 || r1 !== sr1)
                hold_bad = 1;
        end
        if (hold > 0) begin
            checks++;
            if (hold_bad !== 1'b0) begin failures++; $display("FAIL %s hold_stable: got unstable expected stable", name); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (ov0 !== 1'b0 || ov1 !== 1'b0 || ready0 !== 1'b1 || ready1 !== 1'b1) begin
            failures++;
            $display("FAIL %s drain: got ov=%b/%b rdy=%b/%b expected ov=0/0 rdy=1/1", name, ov0, ov1, ready0, ready1);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ov0 !== 1'b0 || q0 !== 64'h0 || r0 !== 64'h0 || ov1 !== 1'b0 || q1 !== 64'h0 || r1 !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs: got ov=%b q=%h r=%h expected 0", ov0, q0, r0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b/%b expected 1/1", ready0, ready1);
        end
    endtask

    task automatic test_unsigned();
        run_op("u_100_7", 64'd100, 64'd7, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            run_op("u_rand", {$urandom, $urandom} >> $urandom_range(0, 40),
                   ({$urandom, $urandom} >> $urandom_range(0, 62)) | 64'd1, 0, 0, 0);
    endtask

    task automatic test_signed();
        run_op("s_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0);
        run_op("s_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0);
        for (int i = 0; i < 6; i++)
            run_op("s_rand", {$urandom, $urandom}, ({$urandom, $urandom} >>> $urandom_range(0, 60)) | 64'd1, 1, 0, 0);
    endtask

    task automatic test_special();
        run_op("div0", 64'h1234, 64'h0, 0, 0, 0);
        run_op("ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        run_op("div0_s", 64'hFFFF_FFFF_FFFF_FF00, 64'h0, 1, 0, 0);
        run_op("w_div0_hi", 64'hDEAD_0000_0000_0055, 64'hABCD_0000_0000_0000, 1, 1, 0);
    endtask

    task automatic test_wmode();
        run_op("divuw", 64'h0000_0000_FFFF_FFFE, 64'd1, 0, 1, 0);
        run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 1, 0);
        run_op("divw_garbage", 64'hA5A5_1234_0000_0014, 64'h5A5A_8765_0000_0003, 1, 1, 0);
        for (int i = 0; i < 6; i++)
            run_op("w_rand", {$urandom, $urandom}, {$urandom, $urandom >> $urandom_range(0, 30)},
                   1'($urandom), 1, 0);
    endtask

    task automatic test_early_out();
        run_op("eo_5_3", 64'd5, 64'd3, 0, 0, 0);
        run_op("eo_zero", 64'd0, 64'd5, 0, 0, 0);
        run_op("eo_w_neg", 64'h0000_0000_FFFF_FFF0, 64'd3, 1, 1, 0);
    endtask

    task automatic test_backpressure();
        run_op("bp", 64'd1000, 64'd33, 0, 0, 5);
    endtask

    task automatic test_flush();
        bit seen;
        div_valid = 1'b1; dividend = 64'hF000_0000_0000_0001; divisor = 64'd3;
        div_signed = 1'b0; divw = 1'b0;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1; div_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; div_valid = 1'b0;
        checks++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: got rdy=%b/%b ov=%b/%b expected rdy=1/1 ov=0/0", ready0, ready1, ov0, ov1);
        end
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (ov0 || ov1) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_result: got 1 expected 0"); end
        run_op("after_flush", 64'd9, 64'd4, 0, 0, 0);
    endtask

    task automatic test_rst_mid();
        div_valid = 1'b1; dividend = 64'hFFFF_0000_1234_5678; divisor = 64'd7;
        div_signed = 1'b0; divw = 1'b0;
        @(posedge clk); #1;
        div_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q0 !== 64'h0 || r0 !== 64'h0 || q1 !== 64'h0 || r1 !== 64'h0 || ov0 !== 1'b0 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got q=%h/%h r=%h/%h expected 0", q0, q1, r0, r1);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op("after_rst", 64'd77, 64'd10, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_wmode();
        test_early_out();
        test_backpressure();
        test_flush();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
